mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one sequential 16x16 multiplier (normal_multiplier: operands a/b, 32-bit out, finished flag) between NUM_REQ independent requesters.
- Round-robin arbitration; captures the winner's operands, launches the multiplier with a start pulse, waits for done, returns the product to the winner.
- Watchdog aborts a hung multiply with an error response.
- Sits between requesting datapath blocks and the single multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand width; product is 2*WIDTH
- TIMEOUT, 64, max cycles in WAIT before abort (>= 2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing
- resp_valid  out  NUM_REQ  one-hot response valid to the granted requester
- resp_ready  in  NUM_REQ  per-requester response accept
- resp_data  out  2*WIDTH  product (0 on error)
- resp_err  out  1  timeout flag, qualified by resp_valid
- mul_a  out  WIDTH  operand A to multiplier
- mul_b  out  WIDTH  operand B to multiplier
- mul_start  out  1  one-cycle launch pulse
- mul_out  in  2*WIDTH  multiplier product
- mul_done  in  1  multiplier finished, sampled only in WAIT
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n low): state=IDLE, rr pointer=0, grant=0, mul_a=mul_b=0, mul_start=0, resp_valid=0, resp_data=0, resp_err=0, watchdog=0, busy=0. req_ready is combinational and is therefore 0 outside IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching from rr pointer upward with wrap (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - req_ready[winner]=1 combinationally in that cycle.
  - On that edge: latch grant=winner, mul_a/mul_b=winner's operands, rr pointer=(winner+1) mod NUM_REQ, go ISSUE.
  - No valid requests: stay in IDLE, all outputs unchanged.
- ISSUE: mul_start=1 for exactly this cycle; clear watchdog; go WAIT. mul_a/mul_b held stable from ISSUE until return to IDLE.
- WAIT:
  - Watchdog increments each cycle.
  - mul_done=1: resp_data<=mul_out, resp_err<=0, go RESP.
  - Otherwise, when watchdog reaches TIMEOUT-1: resp_data<=0, resp_err<=1, go RESP.
  - mul_done on the same cycle as the timeout takes priority, giving a normal result.
- RESP:
  - resp_valid[grant]=1; resp_data/resp_err held.
  - On resp_ready[grant]: clear resp_valid, go IDLE.
  - resp_ready on any other bit is ignored. Backpressure may last indefinitely.
- Latency: accept edge at cycle T; mul_start high in T+1; mul_done first sampled in T+2; resp_valid earliest in T+3.
- Throughput: one transaction in flight. The next accept can occur in the cycle after the resp handshake.
- mul_done outside WAIT (stray or late) is ignored. A late done after a timeout does not corrupt the next transaction, because the watchdog is cleared in ISSUE.
- Requests arriving while busy are not accepted. Requesters hold req_valid and operands until req_ready.
- rst_n asserted mid-transaction: immediate return to reset values. The in-flight result is lost and no response is produced.
- Arithmetic: unsigned; resp_data is mul_out passed through unmodified, full 2*WIDTH bits.

Test Plan:
- Single request: req0 a=1234, b=4321; model done 16 cycles after start -> req_ready[0] one cycle, mul_start one pulse, resp_valid=4'b0001, resp_data=5332114, resp_err=0.
- Max operands: req2 a=b=16'hFFFF -> resp_data=32'hFFFE0001 to requester 2 only.
- All four valid continuously from reset, with distinct operands -> grant order 0,1,2,3,0; each response goes to the correct requester with the correct product.
- Timeout: model never asserts mul_done, TIMEOUT=64 -> resp_valid at WAIT entry +63 cycles, resp_data=0, resp_err=1. Next request completes normally, including when a stray mul_done arrives in IDLE.
- Backpressure: hold resp_ready[1]=0 for 20 cycles with req0 also valid -> resp_data stable, req_ready all 0, busy=1. After release, req0 is accepted on the next IDLE cycle.
- Reset mid-WAIT: pull rst_n low -> all outputs return to reset values asynchronously. After release, a new request at requester 0 is granted first (rr pointer=0).

Source files
------------

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one sequential multiplier among NUM_REQ requesters,
// with a watchdog that turns a hung multiply into an error response.
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [2*WIDTH-1:0]       resp_data,
    output logic                     resp_err,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_start,
    input  logic [2*WIDTH-1:0]       mul_out,
    input  logic                     mul_done,
    output logic                     busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t               state_q;
    logic [IW-1:0]        rr_q, grant_q, win, idx, rr_d;
    logic [TW-1:0]        wd_q;
    logic [WIDTH-1:0]     mul_a_q, mul_b_q, win_a, win_b;
    logic                 mul_start_q, resp_err_q, found;
    logic [NUM_REQ-1:0]   resp_valid_q;
    logic [2*WIDTH-1:0]   resp_data_q;
    // Descending scan so the valid requester closest to the pointer is written last and wins.
    always_comb begin
        win = '0;
        idx = '0;
        win_a = '0;
        win_b = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_q) + k) % NUM_REQ);
            win = req_valid[idx] ? idx : win;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            win_a = (win == IW'(k)) ? req_a[k*WIDTH +: WIDTH] : win_a;
            win_b = (win == IW'(k)) ? req_b[k*WIDTH +: WIDTH] : win_b;
        end
    end
    assign found      = |req_valid;
    assign rr_d       = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign req_ready  = (state_q == IDLE) ? NUM_REQ'(found) << win : '0;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_start  = mul_start_q;
    assign busy       = state_q != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            grant_q      <= '0;
            wd_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_start_q  <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    grant_q     <= win;
                    mul_a_q     <= win_a;
                    mul_b_q     <= win_b;
                    rr_q        <= rr_d;
                    mul_start_q <= 1'b1;
                    state_q     <= ISSUE;
                end
                ISSUE: begin
                    mul_start_q <= 1'b0;
                    wd_q        <= '0;
                    state_q     <= WAIT;
                end
                // WAIT lasts at most TIMEOUT-1 cycles; a done in the last one still wins.
                WAIT: if (mul_done || wd_q == TW'(TIMEOUT - 2)) begin
                    resp_data_q  <= mul_done ? mul_out : '0;
                    resp_err_q   <= !mul_done;
                    resp_valid_q <= NUM_REQ'(1) << grant_q;
                    state_q      <= RESP;
                end else begin
                    wd_q <= wd_q + 1'b1;
                end
                RESP: if (resp_ready[grant_q]) begin
                    resp_valid_q <= '0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench with a behavioural sequential multiplier and queued requesters.
module tb_mul_share_arbiter;
    logic        clk = 0, rst_n;
    logic [3:0]  req_valid = '0, req_ready, resp_valid, resp_ready;
    logic [63:0] req_a = '0, req_b = '0;
    logic [31:0] resp_data, mul_out;
    logic        resp_err, mul_start, mul_done, busy;
    logic [15:0] mul_a, mul_b;
    mul_share_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .mul_a(mul_a), .mul_b(mul_b),
        .mul_start(mul_start), .mul_out(mul_out), .mul_done(mul_done), .busy(busy)
    );
    always #5 clk = ~clk;
    typedef struct {int idx; logic [31:0] data; logic err;} exp_t;
    exp_t        exp_q[$];
    exp_t        e_m;
    logic [15:0] qa[4][$], qb[4][$];
    logic [3:0]  acc, oh;
    int          errors = 0, checks = 0, nresp = 0, starts = 0, r0 = 0;
    int          lat, cnt, k, t, bad, s0, r00;
    logic        hang, stray;
    logic [31:0] prod;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, want);
        end
    endtask
    task automatic add_req(input int i, input logic [15:0] a, input logic [15:0] b);
        qa[i].push_back(a);
        qb[i].push_back(b);
    endtask
    task automatic push_exp(input int i, input logic [31:0] d, input logic er);
        exp_t e;
        e.idx = i; e.data = d; e.err = er;
        exp_q.push_back(e);
    endtask
    task automatic wait_resp(input int n);
        for (int w = 0; w < 2000 && nresp < n; w++) @(negedge clk);
        chk("resp_count_reached", 64'(nresp >= n), 1);
    endtask
    task automatic wait_start();
        for (int w = 0; w < 200 && !mul_start; w++) @(negedge clk);
        chk("start_seen", mul_start, 1);
    endtask
    // Behavioural multiplier: product registered at start, done pulses lat cycles later unless hung.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else if (mul_start && !hang) begin
            cnt  <= lat;
            prod <= 32'(mul_a) * 32'(mul_b);
        end else if (cnt != 0) cnt <= cnt - 1;
    end
    assign mul_done = (cnt == 1) || stray;
    assign mul_out  = prod;
    // Requesters hold valid/operands until accepted, then move to their next queued operation.
    always begin
        @(negedge clk);
        acc = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && rst_n) begin
                void'(qa[i].pop_front());
                void'(qb[i].pop_front());
            end
            req_valid[i]      = qa[i].size() != 0;
            req_a[i*16 +: 16] = (qa[i].size() != 0) ? qa[i][0] : 16'd0;
            req_b[i*16 +: 16] = (qb[i].size() != 0) ? qb[i][0] : 16'd0;
        end
    end
    always @(negedge clk) begin
        if (rst_n && (resp_valid & resp_ready) != 0) begin
            chk("resp_onehot", 64'($onehot(resp_valid)), 1);
            if (exp_q.size() == 0) chk("resp_unexpected", resp_valid, 0);
            else begin
                e_m = exp_q.pop_front();
                oh  = 4'b1 << e_m.idx;
                chk("resp_target", resp_valid, oh);
                chk("resp_data", resp_data, e_m.data);
                chk("resp_err", resp_err, e_m.err);
            end
            nresp++;
        end
        if (mul_start) starts++;
        if (req_ready[0]) r0++;
    end
    initial begin
        rst_n = 0; resp_ready = 4'hF; hang = 0; stray = 0; lat = 16;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_ab", {mul_a, mul_b}, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        rst_n = 1;
        s0 = starts; r00 = r0;
        push_exp(0, 32'd5332114, 0); add_req(0, 16'd1234, 16'd4321);
        wait_resp(1);
        chk("single_start_pulses", 64'(starts - s0), 1);
        chk("single_ready_cycles", 64'(r0 - r00), 1);
        chk("single_mul_ab_held", {mul_a, mul_b}, {16'd1234, 16'd4321});
        lat = 1;
        push_exp(1, 32'd6, 0); add_req(1, 16'd2, 16'd3);
        for (t = 0; t < 50 && req_ready == 0; t++) @(negedge clk);
        for (k = 0; k < 50 && resp_valid == 0; k++) @(negedge clk);
        chk("min_latency", 64'(k), 3);
        wait_resp(2);
        lat = 16;
        push_exp(2, 32'hFFFE0001, 0); add_req(2, 16'hFFFF, 16'hFFFF);
        wait_resp(3);
        rst_n = 0;
        push_exp(0, 32'd15, 0);    add_req(0, 16'd3, 16'd5);
        push_exp(1, 32'd20000, 0); add_req(1, 16'd100, 16'd200);
        push_exp(2, 32'd65536, 0); add_req(2, 16'h1000, 16'h0010);
        push_exp(3, 32'd63, 0);    add_req(3, 16'd7, 16'd9);
        push_exp(0, 32'd143, 0);   add_req(0, 16'd11, 16'd13);
        repeat (2) @(negedge clk);
        rst_n = 1;
        wait_resp(8);
        hang = 1;
        push_exp(3, 32'd0, 1); add_req(3, 16'd5, 16'd6);
        wait_start();
        for (k = 0; k < 200 && resp_valid == 0; k++) @(negedge clk);
        chk("timeout_latency", 64'(k), 64);
        wait_resp(9);
        hang = 0;
        @(negedge clk);
        stray = 1;
        @(negedge clk);
        stray = 0;
        chk("stray_done_busy", busy, 0);
        chk("stray_done_resp", resp_valid, 0);
        push_exp(0, 32'd120000, 0); add_req(0, 16'd300, 16'd400);
        wait_resp(10);
        resp_ready = 4'b1101;
        push_exp(1, 32'd1000000, 0); add_req(1, 16'd1000, 16'd1000);
        push_exp(0, 32'd81, 0);      add_req(0, 16'd9, 16'd9);
        for (t = 0; t < 100 && resp_valid != 4'b0010; t++) @(negedge clk);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_data !== 32'd1000000 || req_ready !== 4'b0 || busy !== 1'b1 || resp_valid !== 4'b0010) bad++;
        end
        chk("backpressure_hold", 64'(bad), 0);
        resp_ready = 4'hF;
        @(negedge clk);
        chk("backpressure_next_accept", req_ready, 4'b0001);
        wait_resp(12);
        hang = 1;
        add_req(2, 16'd7, 16'd7);
        wait_start();
        repeat (3) @(negedge clk);
        chk("midwait_busy", busy, 1);
        rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_resp_data", resp_data, 0);
        chk("arst_resp_err", resp_err, 0);
        chk("arst_mul_ab", {mul_a, mul_b}, 0);
        chk("arst_mul_start", mul_start, 0);
        chk("arst_req_ready", req_ready, 0);
        hang = 0;
        push_exp(0, 32'd4, 0); add_req(0, 16'd2, 16'd2);
        push_exp(3, 32'd9, 0); add_req(3, 16'd3, 16'd3);
        repeat (2) @(negedge clk);
        rst_n = 1;
        wait_resp(14);
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
